ip_tx_arbiter: RTL and testbench
================================

Name: ip_tx_arbiter

Overview:
- Shares the single IP transmit path between two upper-layer AXI-Stream sources: channel 0 is ICMP and channel 1 is UDP.
- Arbitration is packet-granular round-robin. Once a source is granted, its whole packet passes through before any switch.
- Output is one registered AXIS stage that feeds the IP TX header builder. User field is {16 len, 3 flag, 8 type, 13 offset, 16 ID}, identical on input and output.
- Also keeps per-channel sent-packet counters for status readout.

Parameters:
- P_DATA_W, 64, stream data width.
- P_USER_W, 56, user sideband width.
- P_CNT_W, 16, width of each packet counter.

Ports:
- i_clk, input, 1: single clock for the whole block.
- i_rst, input, 1: synchronous, active-high reset.
- s_axis_c0_data / _user / _keep / _last / _valid, input, 64 / 56 / 8 / 1 / 1: channel 0 (ICMP) stream.
- s_axis_c0_ready, output, 1: accept for channel 0.
- s_axis_c1_data / _user / _keep / _last / _valid, input, 64 / 56 / 8 / 1 / 1: channel 1 (UDP) stream.
- s_axis_c1_ready, output, 1: accept for channel 1.
- m_axis_ip_data / _user / _keep / _last / _valid, output, 64 / 56 / 8 / 1 / 1: merged stream to IP TX.
- m_axis_ip_ready, input, 1: downstream accept.
- o_grant, output, 2: one-hot grant. 00 means idle.
- o_c0_pkt_cnt, output, 16: packets completed on channel 0.
- o_c1_pkt_cnt, output, 16: packets completed on channel 1.

Behaviour:
- Reset: all outputs go to 0 (data, user, keep, last, valid, ready, grant, counters). State = IDLE. Round-robin pointer = channel 0 preferred.
- FSM has three states: IDLE, GRANT_C0, GRANT_C1.
- IDLE, transitions:
  - Only c0 valid: go to GRANT_C0.
  - Only c1 valid: go to GRANT_C1.
  - Both valid: grant the channel the pointer prefers.
  - Neither valid: stay in IDLE.
  - Decision is registered: grant is asserted the cycle after valid is seen.
- IDLE, outputs: no ready is asserted.
- GRANT_Cn:
  - s_axis_cn_ready = !m_axis_ip_valid || m_axis_ip_ready.
  - The other channel's ready is 0.
- Beat accept (cn valid & ready): all cn fields load into the output register and m_axis_ip_valid <= 1. Latency is 1 cycle.
- Output register, no accept this cycle:
  - If m_axis_ip_ready is high, m_axis_ip_valid <= 0.
  - If m_axis_ip_ready is low, data, user, keep, last and valid all hold.
- Accepted beat with last = 1:
  - Next state is IDLE.
  - Pointer moves to prefer the other channel.
  - o_cn_pkt_cnt increments, wrapping 0xFFFF -> 0.
- Spacing: one IDLE arbitration cycle always separates packets, so minimum gap on the input side is 1 cycle. Back-to-back output beats within a packet are sustained at full rate.
- Packet integrity:
  - Grant never changes mid-packet.
  - If the granted source drops valid mid-packet, the block waits indefinitely, with no timeout.
  - A non-granted source holding valid is stalled with ready = 0 and is never dropped.
- Single-beat packet (last on the first beat): legal. Counted, then back to IDLE.
- Pass-through: keep and user are copied unchanged. The block does no length checks.
- Reset mid-packet: the partial packet is abandoned and m_axis_ip_last is never issued for it. Upstream sources must also be reset by the same i_rst.
- Both valid again straight after a c0 packet: c1 wins (fairness).

Decomposition:
- Shared package holds:
  - state encoding (IDLE, GRANT_C0, GRANT_C1);
  - channel index constants (CH_ICMP = 0, CH_UDP = 1);
  - user-field bit offsets: len [55:40], flag [39:37], type [36:29], offset [28:16], ID [15:0].
- One sub-module is natural: axis_out_reg, the single-stage registered AXIS output with ready/valid hold. It is reusable by other TX muxes.
- The arbiter FSM and the counters stay in the top module.

Test Plan:
1. c0 alone, 3-beat packet D0/D1/D2, last keep = 0xF0, m_ready = 1. Required:
   - grant = 01 one cycle after valid;
   - m_valid on the 3 following cycles;
   - m_last with keep 0xF0 on the third beat;
   - o_c0_pkt_cnt = 1; o_grant = 00 afterwards.
2. c0 and c1 both valid from reset, each with 2-beat packets, repeated. Required:
   - output order c0, c1, c0, c1;
   - one idle cycle between packets;
   - counters 2/2 after 4 packets.
3. m_ready held low for 5 cycles mid-packet. Required:
   - m_data, m_user and m_valid stable across the stall;
   - s_ready = 0 during the stall;
   - no beat lost or duplicated;
   - packet completes once ready returns.
4. Granted c1 drops valid for 4 cycles mid-packet while c0 is valid. Required: grant stays 10, c0 ready stays 0, and c1's packet resumes and completes before c0 is served.
5. i_rst pulsed for 1 cycle on beat 2 of a 4-beat c0 packet. Required:
   - next cycle: all outputs 0, counters 0, grant 00;
   - a new c1 packet is then granted normally.
6. c0 sends 65536 single-beat packets. Required: o_c0_pkt_cnt wraps to 0 and o_c1_pkt_cnt stays unchanged.

Source files
------------

// File: rtl/ip_tx_arbiter_pkg.sv
// Shared types and constants for the IP TX arbiter: FSM encoding, channel
// indices and the bit layout of the AXIS user sideband.
package ip_tx_arbiter_pkg;

  // Encoding doubles as the one-hot grant: bit 0 = ICMP, bit 1 = UDP.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_GRANT_C0 = 2'b01,
    ST_GRANT_C1 = 2'b10
  } arb_state_t;

  localparam logic CH_ICMP = 1'b0;
  localparam logic CH_UDP  = 1'b1;

  localparam int USER_LEN_MSB  = 55;
  localparam int USER_LEN_LSB  = 40;
  localparam int USER_FLAG_MSB = 39;
  localparam int USER_FLAG_LSB = 37;
  localparam int USER_TYPE_MSB = 36;
  localparam int USER_TYPE_LSB = 29;
  localparam int USER_OFF_MSB  = 28;
  localparam int USER_OFF_LSB  = 16;
  localparam int USER_ID_MSB   = 15;
  localparam int USER_ID_LSB   = 0;

  function automatic logic [1:0] grant_of(input arb_state_t s);
    return s;
  endfunction

endpackage

// File: rtl/ip_tx_arbiter_axis_out_reg.sv
// Single registered AXIS stage. Holds its beat while the sink stalls and
// reports when a new beat may be loaded this cycle.
module ip_tx_arbiter_axis_out_reg #(
  parameter int P_DATA_W = 64,
  parameter int P_USER_W = 56
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_load,
  input  logic [P_DATA_W-1:0]   i_data,
  input  logic [P_USER_W-1:0]   i_user,
  input  logic [P_DATA_W/8-1:0] i_keep,
  input  logic                  i_last,
  input  logic                  i_ready,
  output logic                  o_space,
  output logic [P_DATA_W-1:0]   o_data,
  output logic [P_USER_W-1:0]   o_user,
  output logic [P_DATA_W/8-1:0] o_keep,
  output logic                  o_last,
  output logic                  o_valid
);

  logic [P_DATA_W-1:0]   r_data;
  logic [P_USER_W-1:0]   r_user;
  logic [P_DATA_W/8-1:0] r_keep;
  logic                  r_last;
  logic                  r_valid;

  // Empty, or the held beat leaves on this edge: full rate without a skid.
  assign o_space = !r_valid || i_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_data  <= '0;
      r_user  <= '0;
      r_keep  <= '0;
      r_last  <= 1'b0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_user  <= i_user;
      r_keep  <= i_keep;
      r_last  <= i_last;
      r_valid <= 1'b1;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_data  = r_data;
  assign o_user  = r_user;
  assign o_keep  = r_keep;
  assign o_last  = r_last;
  assign o_valid = r_valid;

endmodule

// File: rtl/ip_tx_arbiter.sv
// Packet-granular round-robin merge of the ICMP (c0) and UDP (c1) streams into
// the IP TX path, with per-channel completed-packet counters.
module ip_tx_arbiter
  import ip_tx_arbiter_pkg::*;
#(
  parameter int P_DATA_W = 64,
  parameter int P_USER_W = 56,
  parameter int P_CNT_W  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [P_DATA_W-1:0]   s_axis_c0_data,
  input  logic [P_USER_W-1:0]   s_axis_c0_user,
  input  logic [P_DATA_W/8-1:0] s_axis_c0_keep,
  input  logic                  s_axis_c0_last,
  input  logic                  s_axis_c0_valid,
  output logic                  s_axis_c0_ready,
  input  logic [P_DATA_W-1:0]   s_axis_c1_data,
  input  logic [P_USER_W-1:0]   s_axis_c1_user,
  input  logic [P_DATA_W/8-1:0] s_axis_c1_keep,
  input  logic                  s_axis_c1_last,
  input  logic                  s_axis_c1_valid,
  output logic                  s_axis_c1_ready,
  output logic [P_DATA_W-1:0]   m_axis_ip_data,
  output logic [P_USER_W-1:0]   m_axis_ip_user,
  output logic [P_DATA_W/8-1:0] m_axis_ip_keep,
  output logic                  m_axis_ip_last,
  output logic                  m_axis_ip_valid,
  input  logic                  m_axis_ip_ready,
  output logic [1:0]            o_grant,
  output logic [P_CNT_W-1:0]    o_c0_pkt_cnt,
  output logic [P_CNT_W-1:0]    o_c1_pkt_cnt
);

  // Handshake: a beat moves on any edge where valid and ready are both high;
  // valid never waits on ready, ready is only offered to the granted channel.
  arb_state_t           r_state;
  logic                 r_ptr;
  logic [P_CNT_W-1:0]   r_c0_cnt;
  logic [P_CNT_W-1:0]   r_c1_cnt;

  logic                  w_space;
  logic                  w_sel_c1;
  logic                  w_c0_acc;
  logic                  w_c1_acc;
  logic                  w_load;
  logic [P_DATA_W-1:0]   w_data;
  logic [P_USER_W-1:0]   w_user;
  logic [P_DATA_W/8-1:0] w_keep;
  logic                  w_last;

  assign s_axis_c0_ready = (r_state == ST_GRANT_C0) && w_space;
  assign s_axis_c1_ready = (r_state == ST_GRANT_C1) && w_space;
  assign w_c0_acc        = s_axis_c0_valid && s_axis_c0_ready;
  assign w_c1_acc        = s_axis_c1_valid && s_axis_c1_ready;
  assign w_load          = w_c0_acc || w_c1_acc;

  assign w_sel_c1 = (r_state == ST_GRANT_C1);
  assign w_data   = w_sel_c1 ? s_axis_c1_data : s_axis_c0_data;
  assign w_user   = w_sel_c1 ? s_axis_c1_user : s_axis_c0_user;
  assign w_keep   = w_sel_c1 ? s_axis_c1_keep : s_axis_c0_keep;
  assign w_last   = w_sel_c1 ? s_axis_c1_last : s_axis_c0_last;

  ip_tx_arbiter_axis_out_reg #(
    .P_DATA_W (P_DATA_W),
    .P_USER_W (P_USER_W)
  ) u_out_reg (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (w_load),
    .i_data  (w_data),
    .i_user  (w_user),
    .i_keep  (w_keep),
    .i_last  (w_last),
    .i_ready (m_axis_ip_ready),
    .o_space (w_space),
    .o_data  (m_axis_ip_data),
    .o_user  (m_axis_ip_user),
    .o_keep  (m_axis_ip_keep),
    .o_last  (m_axis_ip_last),
    .o_valid (m_axis_ip_valid)
  );

  // r_ptr names the channel that wins a tie in IDLE.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_ptr    <= CH_ICMP;
      r_c0_cnt <= '0;
      r_c1_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (s_axis_c0_valid && (!s_axis_c1_valid || r_ptr == CH_ICMP))
            r_state <= ST_GRANT_C0;
          else if (s_axis_c1_valid)
            r_state <= ST_GRANT_C1;
        end
        ST_GRANT_C0: begin
          if (w_c0_acc && s_axis_c0_last) begin
            r_state  <= ST_IDLE;
            r_ptr    <= CH_UDP;
            r_c0_cnt <= r_c0_cnt + 1'b1;
          end
        end
        ST_GRANT_C1: begin
          if (w_c1_acc && s_axis_c1_last) begin
            r_state  <= ST_IDLE;
            r_ptr    <= CH_ICMP;
            r_c1_cnt <= r_c1_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_grant      = grant_of(r_state);
  assign o_c0_pkt_cnt = r_c0_cnt;
  assign o_c1_pkt_cnt = r_c1_cnt;

endmodule

// File: tb/tb_ip_tx_arbiter.sv
// Bench for ip_tx_arbiter: vector table, directed corner sequences, and
// randomized traffic checked against a packet-level reference model.
module tb_ip_tx_arbiter;
  import ip_tx_arbiter_pkg::*;

  localparam int EXP_W = 130;

  typedef struct packed {
    logic [63:0] data;
    logic [55:0] user;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  typedef struct {
    logic v; logic [63:0] d; logic [7:0] k; logic l; logic mr;
    logic [1:0] g; logic sr; logic mv; logic [63:0] md; logic [7:0] mk; logic ml;
    logic [15:0] cnt;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [63:0] c0_data, c1_data, m_data;
  logic [55:0] c0_user, c1_user, m_user;
  logic [7:0]  c0_keep, c1_keep, m_keep;
  logic        c0_last, c1_last, m_last;
  logic        c0_valid, c1_valid, m_valid;
  logic        c0_ready, c1_ready, m_ready;
  logic [1:0]  grant;
  logic [15:0] cnt0, cnt1;

  ip_tx_arbiter u_dut (
    .i_clk(clk), .i_rst(rst),
    .s_axis_c0_data(c0_data), .s_axis_c0_user(c0_user), .s_axis_c0_keep(c0_keep),
    .s_axis_c0_last(c0_last), .s_axis_c0_valid(c0_valid), .s_axis_c0_ready(c0_ready),
    .s_axis_c1_data(c1_data), .s_axis_c1_user(c1_user), .s_axis_c1_keep(c1_keep),
    .s_axis_c1_last(c1_last), .s_axis_c1_valid(c1_valid), .s_axis_c1_ready(c1_ready),
    .m_axis_ip_data(m_data), .m_axis_ip_user(m_user), .m_axis_ip_keep(m_keep),
    .m_axis_ip_last(m_last), .m_axis_ip_valid(m_valid), .m_axis_ip_ready(m_ready),
    .o_grant(grant), .o_c0_pkt_cnt(cnt0), .o_c1_pkt_cnt(cnt1)
  );

  // Narrow-counter instance so the wrap can be reached in a short run.
  logic [63:0] w_c0_data, w_c1_data, w_m_data;
  logic [55:0] w_c0_user, w_c1_user, w_m_user;
  logic [7:0]  w_c0_keep, w_c1_keep, w_m_keep;
  logic        w_c0_last, w_c1_last, w_m_last;
  logic        w_c0_valid, w_c1_valid, w_m_valid;
  logic        w_c0_ready, w_c1_ready, w_m_ready;
  logic [1:0]  w_grant;
  logic [7:0]  w_cnt0, w_cnt1;

  ip_tx_arbiter #(.P_CNT_W(8)) u_wrap (
    .i_clk(clk), .i_rst(rst),
    .s_axis_c0_data(w_c0_data), .s_axis_c0_user(w_c0_user), .s_axis_c0_keep(w_c0_keep),
    .s_axis_c0_last(w_c0_last), .s_axis_c0_valid(w_c0_valid), .s_axis_c0_ready(w_c0_ready),
    .s_axis_c1_data(w_c1_data), .s_axis_c1_user(w_c1_user), .s_axis_c1_keep(w_c1_keep),
    .s_axis_c1_last(w_c1_last), .s_axis_c1_valid(w_c1_valid), .s_axis_c1_ready(w_c1_ready),
    .m_axis_ip_data(w_m_data), .m_axis_ip_user(w_m_user), .m_axis_ip_keep(w_m_keep),
    .m_axis_ip_last(w_m_last), .m_axis_ip_valid(w_m_valid), .m_axis_ip_ready(w_m_ready),
    .o_grant(w_grant), .o_c0_pkt_cnt(w_cnt0), .o_c1_pkt_cnt(w_cnt1)
  );

  // ---------------- bench state ----------------
  int checks = 0;
  int errors = 0;

  beat_t src0_q[$], src1_q[$];
  logic [EXP_W-1:0] exp_q[$];
  int out_order[$];
  logic use_q, gate0, gate1, hold0, hold1, m_rdy;
  int acc0, acc1, in_done, beats_out;

  logic [1:0]  mod_owner;
  logic        mod_pref, mod_full;
  logic [15:0] mod_cnt0, mod_cnt1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic logic [55:0] make_user(input logic [15:0] len, input logic [7:0] typ,
                                            input logic [15:0] id);
    logic [55:0] u;
    u = '0;
    u[USER_LEN_MSB:USER_LEN_LSB]   = len;
    u[USER_FLAG_MSB:USER_FLAG_LSB] = 3'b010;
    u[USER_TYPE_MSB:USER_TYPE_LSB] = typ;
    u[USER_OFF_MSB:USER_OFF_LSB]   = 13'd0;
    u[USER_ID_MSB:USER_ID_LSB]     = id;
    return u;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic push_pkt(input int ch, input int nb);
    beat_t b;
    logic [15:0] id;
    id = 16'($urandom);
    for (int i = 0; i < nb; i++) begin
      b.data = {$urandom, $urandom};
      b.user = make_user(16'(nb * 8), (ch != 0) ? 8'd17 : 8'd1, id);
      b.last = (i == nb - 1);
      b.keep = b.last ? 8'($urandom_range(1, 255)) : 8'hFF;
      if (ch == 0) src0_q.push_back(b); else src1_q.push_back(b);
    end
  endtask

  task automatic drive();
    beat_t b;
    if (use_q) begin
      b = '0;
      if (src0_q.size() != 0) b = src0_q[0];
      c0_valid = (src0_q.size() != 0) && (gate0 || hold0);
      {c0_data, c0_user, c0_keep, c0_last} = b;
      b = '0;
      if (src1_q.size() != 0) b = src1_q[0];
      c1_valid = (src1_q.size() != 0) && (gate1 || hold1);
      {c1_data, c1_user, c1_keep, c1_last} = b;
    end
    m_ready = m_rdy;
  endtask

  // Called at negedge+1: check against the model, advance it across the
  // coming posedge, then wait for the next negedge.
  task automatic step();
    logic e_r0, e_r1, a0, a1;
    logic [EXP_W-1:0] e;
    if (rst) begin
      mod_owner = 2'b00; mod_pref = 1'b0; mod_full = 1'b0;
      mod_cnt0 = '0; mod_cnt1 = '0;
      exp_q.delete(); src0_q.delete(); src1_q.delete();
      hold0 = 1'b0; hold1 = 1'b0;
    end else begin
      e_r0 = (mod_owner == 2'b01) && (!mod_full || m_ready);
      e_r1 = (mod_owner == 2'b10) && (!mod_full || m_ready);
      check("grant", 64'(grant), 64'(mod_owner));
      check("cnt0", 64'(cnt0), 64'(mod_cnt0));
      check("cnt1", 64'(cnt1), 64'(mod_cnt1));
      check("m_valid", 64'(m_valid), 64'(mod_full));
      check("c0_ready", 64'(c0_ready), 64'(e_r0));
      check("c1_ready", 64'(c1_ready), 64'(e_r1));
      if (m_valid && m_ready) begin
        beats_out++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_extra_beat actual=%0h required=none t=%0t", m_data, $time);
        end else begin
          e = exp_q.pop_front();
          check("sb_data", m_data, e[63:0]);
          check("sb_user", 64'(m_user), 64'(e[119:64]));
          check("sb_keep", 64'(m_keep), 64'(e[127:120]));
          check("sb_last", 64'(m_last), 64'(e[128]));
          if (e[128]) out_order.push_back(int'(e[129]));
        end
      end
      a0 = c0_valid && e_r0;
      a1 = c1_valid && e_r1;
      if (a0) begin exp_q.push_back({1'b0, c0_last, c0_keep, c0_user, c0_data}); acc0++; end
      if (a1) begin exp_q.push_back({1'b1, c1_last, c1_keep, c1_user, c1_data}); acc1++; end
      if (use_q) begin
        hold0 = c0_valid && !a0;
        hold1 = c1_valid && !a1;
        if (a0) void'(src0_q.pop_front());
        if (a1) void'(src1_q.pop_front());
      end
      mod_full = (a0 || a1) ? 1'b1 : (m_ready ? 1'b0 : mod_full);
      if (mod_owner == 2'b00) begin
        if (c0_valid && (!c1_valid || mod_pref == 1'b0)) mod_owner = 2'b01;
        else if (c1_valid) mod_owner = 2'b10;
      end else if (a0 && c0_last) begin
        mod_owner = 2'b00; mod_pref = 1'b1; mod_cnt0 = mod_cnt0 + 16'd1; in_done++;
      end else if (a1 && c1_last) begin
        mod_owner = 2'b00; mod_pref = 1'b0; mod_cnt1 = mod_cnt1 + 16'd1; in_done++;
      end
    end
    @(negedge clk);
  endtask

  task automatic cyc();
    drive(); #1; step();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) cyc();
    rst = 1'b0;
  endtask

  task automatic run_drain(input string name, input int max_cyc);
    int n;
    n = 0;
    while ((src0_q.size() != 0 || src1_q.size() != 0 || exp_q.size() != 0) && n < max_cyc) begin
      cyc(); n++;
    end
    checks++;
    if (n >= max_cyc) begin
      errors++;
      $display("FAIL %s_timeout actual=%0d cycles required=<%0d", name, n, max_cyc);
    end
  endtask

  task automatic wrap_send(input int npkt);
    int acc, n;
    acc = 0; n = 0;
    w_c0_valid = 1'b1;
    while (acc < npkt && n < 4 * npkt + 10) begin
      @(negedge clk);
      w_c0_data = 64'(n);
      #1;
      if (w_c0_valid && w_c0_ready) acc++;
      n++;
    end
    @(negedge clk);
    w_c0_valid = 1'b0;
    checks++;
    if (acc < npkt) begin
      errors++;
      $display("FAIL wrap_timeout actual=%0d required=%0d", acc, npkt);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    vec_t tv[6];
    logic [55:0] u0;
    logic [63:0] cap_d;
    logic [55:0] cap_u;
    int base, idle, n;
    logic seen;

    {c0_data, c0_user, c0_keep, c0_last, c0_valid} = '0;
    {c1_data, c1_user, c1_keep, c1_last, c1_valid} = '0;
    {w_c0_data, w_c0_user, w_c0_keep, w_c0_valid} = '0;
    {w_c1_data, w_c1_user, w_c1_keep, w_c1_last, w_c1_valid} = '0;
    w_c0_last = 1'b1; w_c0_keep = 8'hFF; w_m_ready = 1'b1;
    use_q = 1'b0; gate0 = 1'b1; gate1 = 1'b1; hold0 = 1'b0; hold1 = 1'b0; m_rdy = 1'b1;
    acc0 = 0; acc1 = 0; in_done = 0; beats_out = 0;
    rst = 1'b1;
    @(negedge clk);
    do_reset(3);

    // Test 1: table of per-cycle vectors, lone 3-beat c0 packet.
    u0 = make_user(16'd24, 8'd1, 16'h1234);
    tv[0] = '{1'b1, 64'hD0, 8'hFF, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 64'h0,  8'h00, 1'b0, 16'd0};
    tv[1] = '{1'b1, 64'hD0, 8'hFF, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 64'h0,  8'h00, 1'b0, 16'd0};
    tv[2] = '{1'b1, 64'hD1, 8'hFF, 1'b0, 1'b1, 2'b01, 1'b1, 1'b1, 64'hD0, 8'hFF, 1'b0, 16'd0};
    tv[3] = '{1'b1, 64'hD2, 8'hF0, 1'b1, 1'b1, 2'b01, 1'b1, 1'b1, 64'hD1, 8'hFF, 1'b0, 16'd0};
    tv[4] = '{1'b0, 64'h0,  8'h00, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 64'hD2, 8'hF0, 1'b1, 16'd1};
    tv[5] = '{1'b0, 64'h0,  8'h00, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 64'h0,  8'h00, 1'b0, 16'd1};
    for (int i = 0; i < 6; i++) begin
      c0_valid = tv[i].v; c0_data = tv[i].d; c0_keep = tv[i].k; c0_last = tv[i].l;
      c0_user = tv[i].v ? u0 : '0;
      m_ready = tv[i].mr; m_rdy = tv[i].mr;
      #1;
      check("t1_grant", 64'(grant), 64'(tv[i].g));
      check("t1_s_ready", 64'(c0_ready), 64'(tv[i].sr));
      check("t1_m_valid", 64'(m_valid), 64'(tv[i].mv));
      check("t1_cnt0", 64'(cnt0), 64'(tv[i].cnt));
      if (tv[i].mv) begin
        check("t1_m_data", m_data, tv[i].md);
        check("t1_m_keep", 64'(m_keep), 64'(tv[i].mk));
        check("t1_m_last", 64'(m_last), 64'(tv[i].ml));
        check("t1_m_user", 64'(m_user), 64'(u0));
      end
      step();
    end
    {c0_data, c0_user, c0_keep, c0_last, c0_valid} = '0;
    use_q = 1'b1;

    // Test 2: both channels contend from reset; strict alternation.
    do_reset(1);
    out_order.delete();
    push_pkt(0, 2); push_pkt(0, 2); push_pkt(1, 2); push_pkt(1, 2);
    in_done = 0; idle = 0; seen = 1'b0; n = 0;
    while (in_done < 4 && n < 100) begin
      drive(); #1;
      if (grant != 2'b00) seen = 1'b1;
      else if (seen) idle++;
      step(); n++;
    end
    run_drain("t2", 50);
    check("t2_idle_gaps", 64'(idle), 64'd3);
    check("t2_order_len", 64'(out_order.size()), 64'd4);
    if (out_order.size() == 4) begin
      check("t2_order0", 64'(out_order[0]), 64'd0);
      check("t2_order1", 64'(out_order[1]), 64'd1);
      check("t2_order2", 64'(out_order[2]), 64'd0);
      check("t2_order3", 64'(out_order[3]), 64'd1);
    end
    check("t2_cnt0", 64'(cnt0), 64'd2);
    check("t2_cnt1", 64'(cnt1), 64'd2);

    // Test 3: downstream stall mid-packet.
    base = acc0; n = 0;
    beats_out = 0;
    push_pkt(0, 4);
    while (acc0 - base < 2 && n < 50) begin cyc(); n++; end
    m_rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(); #1;
      if (k == 0) begin cap_d = m_data; cap_u = m_user; end
      check("t3_stall_valid", 64'(m_valid), 64'd1);
      check("t3_stall_data", m_data, cap_d);
      check("t3_stall_user", 64'(m_user), 64'(cap_u));
      check("t3_stall_ready", 64'(c0_ready), 64'd0);
      step();
    end
    m_rdy = 1'b1;
    run_drain("t3", 50);
    check("t3_beats", 64'(beats_out), 64'd4);
    check("t3_cnt0", 64'(cnt0), 64'd3);

    // Test 4: granted c1 pauses mid-packet while c0 waits.
    push_pkt(1, 4);
    n = 0;
    while (grant != 2'b10 && n < 20) begin cyc(); n++; end
    check("t4_granted_c1", 64'(grant), 64'b10);
    push_pkt(0, 3);
    base = acc1; n = 0;
    while (acc1 - base < 1 && n < 20) begin cyc(); n++; end
    gate1 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(); #1;
      check("t4_hold_grant", 64'(grant), 64'b10);
      check("t4_c0_ready", 64'(c0_ready), 64'd0);
      step();
    end
    gate1 = 1'b1;
    n = 0;
    while (src1_q.size() != 0 && n < 50) begin cyc(); n++; end
    check("t4_c0_unserved", 64'(src0_q.size()), 64'd3);
    run_drain("t4", 50);
    if (out_order.size() >= 2) begin
      check("t4_order_c1", 64'(out_order[out_order.size()-2]), 64'd1);
      check("t4_order_c0", 64'(out_order[out_order.size()-1]), 64'd0);
    end

    // Test 5: reset on beat 2 of a 4-beat c0 packet.
    push_pkt(0, 4);
    base = acc0; n = 0;
    while (acc0 - base < 1 && n < 20) begin cyc(); n++; end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    drive(); #1;
    check("t5_m_valid", 64'(m_valid), 64'd0);
    check("t5_m_data", m_data, 64'd0);
    check("t5_m_user", 64'(m_user), 64'd0);
    check("t5_m_keep", 64'(m_keep), 64'd0);
    check("t5_m_last", 64'(m_last), 64'd0);
    check("t5_readies", 64'({c0_ready, c1_ready}), 64'd0);
    check("t5_grant", 64'(grant), 64'd0);
    check("t5_cnts", 64'({cnt0, cnt1}), 64'd0);
    step();
    push_pkt(1, 2);
    seen = 1'b0; n = 0;
    while ((src1_q.size() != 0 || exp_q.size() != 0) && n < 30) begin
      drive(); #1;
      if (grant == 2'b10) seen = 1'b1;
      step(); n++;
    end
    check("t5_c1_granted", 64'(seen), 64'd1);
    check("t5_c1_cnt", 64'(cnt1), 64'd1);

    // Random traffic against the model.
    for (int i = 0; i < 500; i++) begin
      if (src0_q.size() < 3 && $urandom_range(0, 3) == 0) push_pkt(0, $urandom_range(1, 5));
      if (src1_q.size() < 3 && $urandom_range(0, 3) == 0) push_pkt(1, $urandom_range(1, 5));
      gate0 = ($urandom_range(0, 3) != 0);
      gate1 = ($urandom_range(0, 3) != 0);
      m_rdy = ($urandom_range(0, 3) != 0);
      cyc();
    end
    gate0 = 1'b1; gate1 = 1'b1; m_rdy = 1'b1;
    run_drain("rand", 200);
    check("rand_sb_empty", 64'(exp_q.size()), 64'd0);

    // Test 6: counter wrap on the narrow-counter instance.
    wrap_send(255);
    repeat (2) @(negedge clk);
    #1;
    check("t6_cnt_ff", 64'(w_cnt0), 64'hFF);
    wrap_send(1);
    repeat (2) @(negedge clk);
    #1;
    check("t6_cnt_wrap", 64'(w_cnt0), 64'd0);
    check("t6_cnt1", 64'(w_cnt1), 64'd0);
    check("t6_grant", 64'(w_grant), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
